// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder: oversamples SCK/MOSI/CSN in axi_aclk and decodes 40-bit frames.
// Optional macro SPI_REG_STATUS_EN shifts {4'b1010, err_cnt} out on MISO during the command byte.
module spi_reg_responder #(
  parameter int NREGS       = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              spi_sck_i,
  input  logic              spi_mosi_i,
  input  logic              spi_csn_i,
  output logic              spi_miso_o,
  output logic              spi_miso_t,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [2:0] {WAIT_CS, IDLE, CMD, RD_REQ, RD_CAP, DATA, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   csn_prev_q, csn_prev_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [DATA_W-2:0]      shin_q, shin_d;
  logic [DATA_W-1:0]      shout_q, shout_d;
  logic                   miso_q, miso_d;
  logic                   miso_t_q, miso_t_d;
  logic                   busy_q, busy_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sck_s, mosi_s, csn_s;
  logic                   sck_rise, sck_fall, csn_rise, csn_fall;
  logic                   in_frame, cmd_bad;
  logic [7:0]             cmd_next;
  logic [DATA_W-1:0]      data_next;
  logic [7:0]             status_byte;

  // Synchronizer shift and edge-detect history.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    csn_s       = csn_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_s;
    csn_prev_d  = csn_s;
    sck_rise    = sck_s & ~sck_prev_q;
    sck_fall    = ~sck_s & sck_prev_q;
    csn_rise    = csn_s & ~csn_prev_q;
    csn_fall    = ~csn_s & csn_prev_q;
  end

`ifdef SPI_REG_STATUS_EN
  logic [3:0] err_cnt_q, err_cnt_d;

  // Saturating count of aborted frames, reported in the status byte.
  always_comb begin
    if (frame_err_d && (err_cnt_q != 4'hF)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    status_byte = {4'b1010, err_cnt_q};
  end

  // Error counter register.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      err_cnt_q <= 4'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`else
  assign status_byte = 8'h00;
`endif

  // Frame decoder: next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    miso_d      = miso_q;
    miso_t_d    = miso_t_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    frame_err_d = 1'b0;
    cmd_next    = {cmd_q[6:0], mosi_s};
    data_next   = {shin_q, mosi_s};
    cmd_bad     = (cmd_next[6:4] != 3'b000) ||
                  (32'(cmd_next[ADDR_W-1:0]) >= 32'(NREGS));
    in_frame    = (state_q == CMD) || (state_q == RD_REQ) ||
                  (state_q == RD_CAP) || (state_q == DATA);

    if (in_frame && csn_rise) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      busy_d      = 1'b0;
      miso_t_d    = 1'b1;
      miso_d      = 1'b0;
    end else begin
      case (state_q)
        WAIT_CS: begin
          if (csn_s) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_CS;
          end
        end
        IDLE: begin
          if (csn_fall) begin
            state_d  = CMD;
            busy_d   = 1'b1;
            miso_t_d = 1'b0;
            cnt_d    = 6'd0;
            miso_d   = status_byte[7];
            shout_d  = {status_byte[6:0], {(DATA_W-7){1'b0}}};
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          if (sck_rise) begin
            cmd_d = cmd_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd7) begin
              shout_d = {DATA_W{1'b0}};
              if (cmd_bad) begin
                state_d = DRAIN;
                miso_d  = 1'b0;
              end else if (cmd_next[7]) begin
                state_d   = RD_REQ;
                rd_en_d   = 1'b1;
                rd_addr_d = cmd_next[ADDR_W-1:0];
              end else begin
                state_d = DATA;
              end
            end else begin
              state_d = CMD;
            end
          end else if (sck_fall) begin
            miso_d  = shout_q[DATA_W-1];
            shout_d = {shout_q[DATA_W-2:0], 1'b0};
          end else begin
            state_d = CMD;
          end
        end
        RD_REQ: state_d = RD_CAP;
        RD_CAP: begin
          // rd_data is valid the cycle after rd_en.
          shout_d = rd_data;
          state_d = DATA;
        end
        DATA: begin
          if (sck_rise) begin
            shin_d = data_next[DATA_W-2:0];
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'd39) begin
              state_d = DRAIN;
              if (!cmd_q[7]) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cmd_q[ADDR_W-1:0];
                wr_data_d = data_next;
              end else begin
                wr_en_d = 1'b0;
              end
            end else begin
              state_d = DATA;
            end
          end else if (sck_fall) begin
            miso_d  = cmd_q[7] & shout_q[DATA_W-1];
            shout_d = {shout_q[DATA_W-2:0], 1'b0};
          end else begin
            state_d = DATA;
          end
        end
        DRAIN: begin
          miso_d = 1'b0;
          if (csn_s) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            miso_t_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d  = WAIT_CS;
          busy_d   = 1'b0;
          miso_t_d = 1'b1;
          miso_d   = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q     <= WAIT_CS;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '0;
      sck_prev_q  <= 1'b0;
      csn_prev_q  <= 1'b0;
      cnt_q       <= 6'd0;
      cmd_q       <= 8'd0;
      shin_q      <= '0;
      shout_q     <= '0;
      miso_q      <= 1'b0;
      miso_t_q    <= 1'b1;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      csn_sync_q  <= csn_sync_d;
      sck_prev_q  <= sck_prev_d;
      csn_prev_q  <= csn_prev_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      miso_q      <= miso_d;
      miso_t_q    <= miso_t_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso_o = miso_q;
  assign spi_miso_t = miso_t_q;
  assign busy       = busy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder (NREGS=8); SCK runs at axi_aclk/8.
module tb_spi_reg_responder;

  logic        clk = 1'b0;
  logic        areset;
  logic        sck, mosi, csn;
  logic        miso, miso_t;
  logic        wr_en, rd_en, busy, frame_err;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;

  int          checks = 0;
  int          failures = 0;
  int          wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0;
  logic [3:0]  last_wr_addr = 4'h0, last_rd_addr = 4'h0;
  logic [31:0] last_wr_data = 32'h0;
  logic [39:0] rx_buf;
  logic        busy_mid;

  spi_reg_responder #(.NREGS(8)) dut (
    .axi_aclk(clk), .axi_areset(areset),
    .spi_sck_i(sck), .spi_mosi_i(mosi), .spi_csn_i(csn),
    .spi_miso_o(miso), .spi_miso_t(miso_t),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= wr_addr;
      last_wr_data <= wr_data;
    end
    if (rd_en) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= rd_addr;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cs_low();
    @(negedge clk);
    csn    = 1'b0;
    rx_buf = 40'h0;
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Clock bits [first, first+n) of tx; MISO is sampled just before each rising edge.
  task automatic spi_bits(input logic [39:0] tx, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      mosi = tx[39-i];
      repeat (4) @(negedge clk);
      rx_buf[39-i] = miso;
      if (i == 10) busy_mid = busy;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [39:0] tx);
    cs_low();
    spi_bits(tx, 0, 40);
    cs_high();
  endtask

  task automatic test_reset();
    areset = 1'b1; csn = 1'b1; sck = 1'b0; mosi = 1'b0; rd_data = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0)   begin failures++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (miso_t !== 1'b1) begin failures++; $display("FAIL reset_miso_t got %b exp 1", miso_t); end
    checks++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL reset_strobes got wr=%b rd=%b exp 0 0", wr_en, rd_en); end
    checks++; if (wr_addr !== 4'h0 || rd_addr !== 4'h0) begin failures++; $display("FAIL reset_addr got %h %h exp 0 0", wr_addr, rd_addr); end
    checks++; if (wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_busy_err got %b %b exp 0 0", busy, frame_err); end
    areset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_status();
    int f0;
`ifdef SPI_REG_STATUS_EN
    for (int k = 0; k < 3; k++) begin
      cs_low();
      spi_bits(40'h80_00000000, 0, 4);
      cs_high();
    end
    rd_data = 32'h0;
    spi_frame(40'h80_00000000);
    checks++; if (rx_buf[39:32] !== 8'hA3) begin failures++; $display("FAIL status_byte got %h exp a3", rx_buf[39:32]); end
`else
    f0 = ferr_cnt;
    rd_data = 32'h0;
    spi_frame(40'h80_00000000);
    checks++; if (rx_buf[39:32] !== 8'h00) begin failures++; $display("FAIL cmd_byte_miso got %h exp 00", rx_buf[39:32]); end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL status_no_err got %0d exp %0d", ferr_cnt, f0); end
`endif
  endtask

  task automatic test_write();
    int w0 = wr_cnt, f0 = ferr_cnt;
    busy_mid = 1'b0;
    spi_frame(40'h03_DEADBEEF);
    checks++; if (wr_cnt !== w0 + 1) begin failures++; $display("FAIL write_count got %0d exp %0d", wr_cnt - w0, 1); end
    checks++; if (last_wr_addr !== 4'h3) begin failures++; $display("FAIL write_addr got %h exp 3", last_wr_addr); end
    checks++; if (last_wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL write_data got %h exp deadbeef", last_wr_data); end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL write_frame_err got %0d exp 0", ferr_cnt - f0); end
    checks++; if (busy_mid !== 1'b1) begin failures++; $display("FAIL write_busy got %b exp 1", busy_mid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_read();
    int r0 = rd_cnt;
    rd_data = 32'h76543210;
    spi_frame(40'h82_00000000);
    checks++; if (rd_cnt !== r0 + 1) begin failures++; $display("FAIL read_count got %0d exp 1", rd_cnt - r0); end
    checks++; if (last_rd_addr !== 4'h2) begin failures++; $display("FAIL read_addr got %h exp 2", last_rd_addr); end
    checks++; if (rx_buf[31:0] !== 32'h76543210) begin failures++; $display("FAIL read_miso got %h exp 76543210", rx_buf[31:0]); end
    checks++; if (miso_t !== 1'b1) begin failures++; $display("FAIL read_miso_t got %b exp 1", miso_t); end
  endtask

  task automatic test_abort();
    int w0 = wr_cnt, f0 = ferr_cnt;
    cs_low();
    spi_bits(40'h05_12345678, 0, 20);
    cs_high();
    checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL abort_no_write got %0d exp 0", wr_cnt - w0); end
    checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL abort_frame_err got %0d exp 1", ferr_cnt - f0); end
    spi_frame(40'h05_00000001);
    checks++; if (wr_cnt !== w0 + 1) begin failures++; $display("FAIL abort_next_count got %0d exp 1", wr_cnt - w0); end
    checks++; if (last_wr_addr !== 4'h5 || last_wr_data !== 32'h1) begin failures++; $display("FAIL abort_next_write got %h/%h exp 5/00000001", last_wr_addr, last_wr_data); end
  endtask

  task automatic test_invalid();
    int w0 = wr_cnt, f0 = ferr_cnt, r0 = rd_cnt;
    spi_frame(40'h43_AAAAAAAA);
    checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL invalid_bits_write got %0d exp 0", wr_cnt - w0); end
    spi_frame(40'h0A_55555555);
    checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL invalid_addr_write got %0d exp 0", wr_cnt - w0); end
    rd_data = 32'hFFFFFFFF;
    spi_frame(40'hCA_00000000);
    checks++; if (rx_buf !== 40'h0) begin failures++; $display("FAIL invalid_read_miso got %h exp 0", rx_buf); end
    checks++; if (rd_cnt !== r0) begin failures++; $display("FAIL invalid_read_strobe got %0d exp 0", rd_cnt - r0); end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL invalid_frame_err got %0d exp 0", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame();
    int w0 = wr_cnt, f0 = ferr_cnt;
    cs_low();
    spi_bits(40'h07_AAAA5555, 0, 12);
    areset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || miso_t !== 1'b1 || miso !== 1'b0) begin failures++; $display("FAIL midreset_outputs got busy=%b t=%b miso=%b exp 0 1 0", busy, miso_t, miso); end
    areset = 1'b0;
    spi_bits(40'h07_AAAA5555, 12, 28);
    cs_high();
    checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL midreset_no_write got %0d exp 0", wr_cnt - w0); end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL midreset_no_err got %0d exp 0", ferr_cnt - f0); end
    spi_frame(40'h01_CAFEF00D);
    checks++; if (wr_cnt !== w0 + 1) begin failures++; $display("FAIL midreset_next_count got %0d exp 1", wr_cnt - w0); end
    checks++; if (last_wr_addr !== 4'h1 || last_wr_data !== 32'hCAFEF00D) begin failures++; $display("FAIL midreset_next_write got %h/%h exp 1/cafef00d", last_wr_addr, last_wr_data); end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt;
    spi_frame(40'h04_0BADF00D);
    checks++; if (last_wr_addr !== 4'h4 || last_wr_data !== 32'h0BADF00D) begin failures++; $display("FAIL b2b_first got %h/%h exp 4/0badf00d", last_wr_addr, last_wr_data); end
    spi_frame(40'h06_13579BDF);
    checks++; if (last_wr_addr !== 4'h6 || last_wr_data !== 32'h13579BDF) begin failures++; $display("FAIL b2b_second got %h/%h exp 6/13579bdf", last_wr_addr, last_wr_data); end
    checks++; if (wr_cnt !== w0 + 2) begin failures++; $display("FAIL b2b_count got %0d exp 2", wr_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_status();
    test_write();
    test_read();
    test_abort();
    test_invalid();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 responder (slave) that lets an external SPI initiator, such as the PS SPI_1 controller routed through IOBUFs, read and write the PL register file.
- Oversamples SCK/MOSI/CSN in the axi_aclk domain and decodes fixed 40-bit frames.
- Issues single-cycle register write/read strobes and drives MISO with a tristate enable for an IOBUF.

Parameters:
- NREGS, 16: number of addressable registers; addresses >= NREGS are out of range.
- ADDR_W, 4: register address width (command bits [3:0]).
- DATA_W, 32: register data width, fixed at 32 for the frame format.
- SYNC_STAGES, 2: synchronizer flops on SCK, MOSI and CSN (minimum 2).

Ports:
- axi_aclk  input  1  system clock; SCK frequency must be <= axi_aclk/8.
- axi_areset  input  1  synchronous reset, active-high.
- spi_sck_i  input  1  SPI clock from IOBUF.
- spi_mosi_i  input  1  SPI data from initiator.
- spi_csn_i  input  1  chip select, active-low.
- spi_miso_o  output  1  SPI data to initiator.
- spi_miso_t  output  1  MISO tristate; 1 = high-Z.
- wr_en  output  1  one-cycle register write strobe.
- wr_addr  output  ADDR_W  write address, valid with wr_en.
- wr_data  output  DATA_W  write data, valid with wr_en.
- rd_en  output  1  one-cycle register read strobe.
- rd_addr  output  ADDR_W  read address, valid with rd_en.
- rd_data  input  DATA_W  read data; sampled in the cycle after rd_en.
- busy  output  1  high while a frame is in progress.
- frame_err  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset values:
  - spi_miso_o=0, spi_miso_t=1.
  - wr_en=0, rd_en=0, wr_addr=0, wr_data=0, rd_addr=0.
  - busy=0, frame_err=0.
  - state=WAIT_CS.
- Frame format:
  - Command byte, MSB first: bit7 = R/nW, bits6:4 must be 000, bits3:0 = address.
  - Followed by 32 data bits, MSB first; 40 bits total.
- Mode 0 timing:
  - MOSI is sampled on synchronized SCK rising edges.
  - MISO is updated on synchronized SCK falling edges.
  - The CSN falling edge loads the first MISO bit.
- States:
  - WAIT_CS: wait for synchronized CSN high -> IDLE. Entered after reset so a frame already in progress is never half-decoded.
  - IDLE: CSN falling -> CMD; busy=1; spi_miso_t=0.
  - CMD: shift 8 bits.
    - On the 8th rising edge, if the command is invalid (bits6:4 != 0 or address >= NREGS) -> DRAIN.
    - Otherwise, for a read: rd_en pulses the next cycle, rd_data is captured one cycle after rd_en into the shift-out register, then -> DATA.
    - Otherwise, for a write: -> DATA.
  - DATA: shift 32 bits.
    - Write: on the 40th rising edge, wr_en/wr_addr/wr_data are presented the following cycle -> DRAIN.
    - Read: rd_data[31] is driven after the 8th falling edge, one bit per subsequent falling edge -> DRAIN after the 40th rising edge.
  - DRAIN: ignore further SCK edges, MISO=0, wait for CSN high -> IDLE; busy=0; spi_miso_t=1.
- Abort and boundary cases:
  - CSN rising in CMD or DATA before bit 40: no wr_en, frame_err pulses once, -> IDLE.
  - Frames longer than 40 bits: extra bits ignored, MISO=0.
  - Invalid reads return 0 on MISO; invalid writes are dropped; neither pulses frame_err.
- Without the optional feature, MISO=0 during the command byte.
- Back-to-back frames are accepted with CSN high for >= 4 axi_aclk cycles (post-synchronizer).
- Reset asserted mid-frame: outputs return to reset values immediately; the block re-arms only after CSN is seen high.

Optional Feature:
- Macro: SPI_REG_STATUS_EN.
- Defined:
  - During the command byte, MISO shifts out the status byte {4'b1010, err_cnt[3:0]}, MSB first.
  - err_cnt counts frame_err pulses, saturates at 15, and clears on reset.
- Undefined: MISO=0 during the command byte; no err_cnt logic.

Test Plan:
- Write 0x03 + 0xDEADBEEF at SCK=axi_aclk/8 -> exactly one wr_en, wr_addr=3, wr_data=0xDEADBEEF, frame_err=0.
- Read 0x82 with rd_data=0x76543210 -> rd_en once with rd_addr=2; MISO bits 9-40 = 0x76543210; spi_miso_t=1 after CSN high.
- CSN raised after 20 bits of write 0x05 + 0x12345678 -> no wr_en, one frame_err pulse; next frame 0x05 + 0x00000001 writes normally.
- Command 0x43 + data, and with NREGS=8 command 0x0A + data -> no wr_en, no frame_err; read 0xCA returns 0x00000000.
- Reset pulsed at bit 12 of a write with CSN held low -> no wr_en, block waits for CSN high; following write 0x01 + 0xCAFEF00D succeeds.
- With SPI_REG_STATUS_EN: three aborted frames then read 0x80 -> first MISO byte = 0xA3.
